// File: rtl/seq_tx_101101_if.sv
// Control and serial-output bundle for the repeated-pattern transmitter.
interface seq_tx_101101_if;
    logic       start;
    logic [3:0] rep_cnt;
    logic [2:0] gap;
    logic       abort;
    logic       out;
    logic       out_vld;
    logic       busy;
    logic       done;
    logic [3:0] rep_left;

    modport master (
        output start, rep_cnt, gap, abort,
        input  out, out_vld, busy, done, rep_left
    );

    modport slave (
        input  start, rep_cnt, gap, abort,
        output out, out_vld, busy, done, rep_left
    );
endinterface

// File: rtl/seq_tx_101101.sv
// Serial burst transmitter: sends PATTERN MSB-first rep_cnt times with
// gap idle bit-times between repetitions; all outputs are registered.
module seq_tx_101101 #(
    parameter int              PLEN    = 6,
    parameter logic [PLEN-1:0] PATTERN = 6'b101101
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_tx_101101_if.slave  bus
);
    localparam int            IW      = (PLEN > 1) ? $clog2(PLEN) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(PLEN - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [2:0]    gap_lat;
    logic [2:0]    gap_cnt;
    logic [3:0]    rep_left;
    logic          out_r;
    logic          out_vld_r;
    logic          busy_r;
    logic          done_r;

    assign bus.out      = out_r;
    assign bus.out_vld  = out_vld_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.rep_left = rep_left;

    // Outputs are loaded together with the next state, so they always
    // reflect the state being entered (Moore behaviour, no comb decode).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= IDX_TOP;
            gap_lat   <= '0;
            gap_cnt   <= '0;
            rep_left  <= '0;
            out_r     <= 1'b0;
            out_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            out_r     <= 1'b0;
            out_vld_r <= 1'b0;
            done_r    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && bus.rep_cnt != '0) begin
                        state     <= SEND;
                        idx       <= IDX_TOP;
                        rep_left  <= bus.rep_cnt;
                        gap_lat   <= bus.gap;
                        busy_r    <= 1'b1;
                        out_r     <= PATTERN[IDX_TOP];
                        out_vld_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        idx      <= IDX_TOP;
                        rep_left <= '0;
                        busy_r   <= 1'b0;
                    end else if (idx == '0) begin
                        rep_left <= rep_left - 4'd1;
                        if (rep_left > 4'd1) begin
                            if (gap_lat != '0) begin
                                state   <= GAP;
                                gap_cnt <= gap_lat;
                            end else begin
                                idx       <= IDX_TOP;
                                out_r     <= PATTERN[IDX_TOP];
                                out_vld_r <= 1'b1;
                            end
                        end else begin
                            state  <= DONE;
                            idx    <= IDX_TOP;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end else begin
                        idx       <= idx - 1'b1;
                        out_r     <= PATTERN[idx - 1'b1];
                        out_vld_r <= 1'b1;
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        idx      <= IDX_TOP;
                        rep_left <= '0;
                        busy_r   <= 1'b0;
                    end else if (gap_cnt == 3'd1) begin
                        state     <= SEND;
                        idx       <= IDX_TOP;
                        out_r     <= PATTERN[IDX_TOP];
                        out_vld_r <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_tx_101101.sv
// Bench for seq_tx_101101: vector table expanded by a burst model into a
// per-cycle expectation queue, plus hand-written reset sequences.
module tb_seq_tx_101101;
    localparam int         PLEN = 6;
    localparam logic [5:0] PAT  = 6'b101101;

    typedef struct packed {
        logic       drv_start;
        logic       drv_abort;
        logic       out;
        logic       vld;
        logic       busy;
        logic       done;
        logic [3:0] rep_left;
    } rec_t;

    typedef struct {
        int r;
        int g;
        int ab;   // 1-based output cycle during which abort is driven, 0 = none
        int st;   // 1-based output cycle during which start is re-pulsed, 0 = none
        bit aws;  // abort driven together with the initial start
    } vec_t;

    logic clk;
    logic rst_n;
    seq_tx_101101_if bus();

    seq_tx_101101 dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   b_n;
    bit   b_stop;
    int   busy_seen;
    int   done_seen;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_rec(input string name, input rec_t e);
        logic [7:0] act, req;
        act = {bus.out, bus.out_vld, bus.busy, bus.done, bus.rep_left};
        req = {e.out, e.vld, e.busy, e.done, e.rep_left};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got out=%b vld=%b busy=%b done=%b rep_left=%0d, expected out=%b vld=%b busy=%b done=%b rep_left=%0d",
                     name, act[7], act[6], act[5], act[4], act[3:0],
                     req[7], req[6], req[5], req[4], req[3:0]);
        end
    endtask

    task automatic add(input rec_t e_in, input int ab, input int st);
        rec_t e;
        e = e_in;
        b_n++;
        e.drv_abort = (b_n == ab);
        e.drv_start = (b_n == st);
        exp_q.push_back(e);
        if (e.drv_abort && e.busy) b_stop = 1'b1;
    endtask

    // Behavioural burst model: one record per cycle after the start edge.
    task automatic build(input int r, input int g, input int ab, input int st);
        rec_t e;
        b_n    = 0;
        b_stop = 1'b0;
        exp_q.delete();
        if (r != 0) begin
            for (int i = 0; i < r && !b_stop; i++) begin
                for (int b = PLEN - 1; b >= 0 && !b_stop; b--) begin
                    e = '0;
                    e.out = PAT[b]; e.vld = 1'b1; e.busy = 1'b1;
                    e.rep_left = 4'(r - i);
                    add(e, ab, st);
                end
                if (i < r - 1)
                    for (int k = 0; k < g && !b_stop; k++) begin
                        e = '0;
                        e.busy = 1'b1;
                        e.rep_left = 4'(r - i - 1);
                        add(e, ab, st);
                    end
            end
            if (!b_stop) begin
                e = '0;
                e.done = 1'b1;
                add(e, ab, st);
            end
        end
        e = '0;
        repeat (3) add(e, ab, st);
    endtask

    task automatic run_stream(input string name);
        rec_t e;
        int   cyc = 0;
        busy_seen = 0;
        done_seen = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            step();
            cyc++;
            busy_seen += int'(bus.busy);
            done_seen += int'(bus.done);
            check_rec($sformatf("%s cyc%0d", name, cyc), e);
            bus.start   = e.drv_start;
            bus.abort   = e.drv_abort;
            bus.rep_cnt = 4'($urandom_range(0, 15));
            bus.gap     = 3'($urandom_range(0, 7));
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d r%0d g%0d", id, v.r, v.g);
        bus.start   = 1'b1;
        bus.abort   = v.aws;
        bus.rep_cnt = 4'(v.r);
        bus.gap     = 3'(v.g);
        build(v.r, v.g, v.ab, v.st);
        run_stream(nm);
        if (v.ab == 0 || v.ab > v.r * PLEN + (v.r - 1) * v.g) begin
            check_val({nm, " busy_cycles"}, busy_seen,
                      (v.r == 0) ? 0 : v.r * PLEN + (v.r - 1) * v.g);
            check_val({nm, " done_pulses"}, done_seen, (v.r == 0) ? 0 : 1);
        end else begin
            check_val({nm, " abort_done_pulses"}, done_seen, 0);
        end
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{r:1,  g:0, ab:0,  st:0, aws:0};
        vecs[1]  = '{r:3,  g:0, ab:0,  st:0, aws:0};
        vecs[2]  = '{r:2,  g:3, ab:0,  st:0, aws:0};
        vecs[3]  = '{r:2,  g:0, ab:4,  st:0, aws:0};
        vecs[4]  = '{r:2,  g:0, ab:0,  st:0, aws:0};
        vecs[5]  = '{r:0,  g:2, ab:0,  st:0, aws:0};
        vecs[6]  = '{r:2,  g:1, ab:0,  st:3, aws:0};
        vecs[7]  = '{r:4,  g:7, ab:0,  st:9, aws:0};
        vecs[8]  = '{r:2,  g:2, ab:7,  st:0, aws:0};
        vecs[9]  = '{r:1,  g:0, ab:7,  st:0, aws:0};
        vecs[10] = '{r:3,  g:1, ab:0,  st:0, aws:1};
        vecs[11] = '{r:15, g:1, ab:0,  st:0, aws:0};

        rst_n       = 1'b0;
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        bus.rep_cnt = 4'd3;
        bus.gap     = 3'd2;
        step();
        step();
        check_rec("reset_state", rec_t'('0));
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        step();
        check_rec("idle_after_reset", rec_t'('0));

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset during GAP, with start and abort also asserted, then start on
        // the first cycle after release.
        bus.start   = 1'b1;
        bus.rep_cnt = 4'd2;
        bus.gap     = 3'd3;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        check_val("in_gap_busy", int'(bus.busy), 1);
        check_val("in_gap_vld", int'(bus.out_vld), 0);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        check_rec("reset_mid_gap", rec_t'('0));
        rst_n       = 1'b1;
        bus.abort   = 1'b0;
        bus.start   = 1'b1;
        bus.rep_cnt = 4'd1;
        bus.gap     = 3'd0;
        build(1, 0, 0, 0);
        run_stream("post_reset_burst");
        check_val("post_reset_busy_cycles", busy_seen, PLEN);
        check_val("post_reset_done", done_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_tx_101101.md
SEQ_TX_101101 -- requirements
Module: seq_tx_101101

Interface
REQ-001 Parameter PATTERN, default 6'b101101, is the serial pattern, sent MSB (bit 5) first.
REQ-002 Parameter PLEN, default 6, is the pattern length in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-006 rep_cnt  input  4  number of pattern repetitions in the burst; sampled with start.
REQ-007 gap  input  3  number of idle bit-times between repetitions; sampled with start.
REQ-008 abort  input  1  synchronous burst cancel.
REQ-009 out  output  1  serial data bit.
REQ-010 out_vld  output  1  out carries a pattern bit this cycle.
REQ-011 busy  output  1  burst in progress (SEND or GAP).
REQ-012 done  output  1  one-cycle pulse on normal burst completion.
REQ-013 rep_left  output  4  repetitions not yet started, including the current one.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, GAP and DONE, with all outputs decoded from registered state (Moore).
REQ-015 In IDLE, the FSM SHALL move to SEND with bit index PLEN-1 when start=1 and rep_cnt!=0, latching rep_cnt and gap.
REQ-016 In IDLE, start with rep_cnt=0 SHALL be ignored: no busy, no done.
REQ-017 The first pattern bit SHALL appear on out in the cycle after the edge that samples start (1-cycle latency).
REQ-018 In SEND, out SHALL equal PATTERN[idx] and out_vld SHALL be 1, with idx decrementing by 1 each cycle.
REQ-019 At idx=0 with rep_left>1 and gap>0, the FSM SHALL go to GAP for exactly gap cycles with out=0 and out_vld=0, then return to SEND at idx=PLEN-1.
REQ-020 At idx=0 with rep_left>1 and gap=0, the FSM SHALL go directly to SEND at idx=PLEN-1, sending back-to-back with no bubble.
REQ-021 rep_left SHALL decrement on the cycle after each idx=0 bit.
REQ-022 At idx=0 with rep_left=1, the FSM SHALL go to DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, busy=0, out=0 and out_vld=0, then return to IDLE.
REQ-024 start SHALL be ignored in SEND, GAP and DONE; a new burst requires start in IDLE.
REQ-025 busy SHALL be 1 in SEND and GAP only.
REQ-026 A burst SHALL occupy exactly rep_cnt*PLEN + (rep_cnt-1)*gap busy cycles.
REQ-027 abort=1 in SEND or GAP SHALL return the FSM to IDLE on the next edge, with out=0, out_vld=0, rep_left=0 and no done pulse.
REQ-028 abort=1 in IDLE or DONE SHALL have no effect, and DONE SHALL still complete.
REQ-029 abort SHALL take priority over every other transition in the same cycle.
REQ-030 Changes on rep_cnt and gap while busy SHALL have no effect on the burst in progress.
REQ-031 out SHALL be 0 whenever out_vld=0.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force IDLE, out=0, out_vld=0, busy=0, done=0, rep_left=0, idx=PLEN-1 and clear the latched gap.
REQ-033 rst_n=0 mid-burst SHALL abandon the burst without a done pulse.
REQ-034 Reset SHALL take priority over abort and start.
REQ-035 After reset release, start sampled in the first cycle SHALL be honoured.

Verification
REQ-036 Single burst: rep_cnt=1, gap=0, start pulse -> out=1,0,1,1,0,1 with out_vld=1 for 6 cycles, then done=1 for 1 cycle, then IDLE.
REQ-037 Back-to-back repetitions: rep_cnt=3, gap=0 -> 18 contiguous valid bits 101101101101101101, rep_left 3->2->1, one done pulse.
REQ-038 Gap between repetitions: rep_cnt=2, gap=3 -> 101101, 3 cycles with out_vld=0, then 101101; busy high for 15 cycles.
REQ-039 Abort mid-pattern: rep_cnt=2, abort asserted on the 4th bit -> IDLE next cycle, out_vld=0, no done; a fresh start then produces a full burst.
REQ-040 Ignored requests: start with rep_cnt=0 -> no activity; start pulsed mid-burst -> burst length unchanged.
REQ-041 Reset mid-burst: rst_n=0 during GAP -> all outputs 0 next cycle, no done; start in the first cycle after release -> burst begins.
